// File: rtl/l2arb_pkg.sv
// l2arb_pkg
// Shared definitions for the L2 port arbiter slice.
//   state_t          : arbiter FSM states (IDLE / BURST / TURN)
//   M_IFETCH, M_DATA : owner index of the instruction-fetch and data masters
//   DIR_READ, DIR_WRITE : latched burst direction encoding
//   dir_of()         : direction taken from a master's request pair (read wins)
package l2arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic M_IFETCH  = 1'b0;
  localparam logic M_DATA    = 1'b1;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  // A master raising rreq and wreq together is treated as a read.
  function automatic logic dir_of(input logic rreq);
    return rreq ? DIR_READ : DIR_WRITE;
  endfunction

endpackage

// File: rtl/l2arb_pick.sv
// l2arb_pick
// Two-request picker used when the arbiter is idle.
// Configuration macro: L2ARB_FIXED_PRIO_EN
//   undefined : round-robin; on a tie the master not granted last wins,
//               and the last-grant pointer resets to m1 so m0 wins first.
//   defined   : fixed priority; m1 (data) always wins, no pointer kept.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset
//   req0     in  m0 (instruction fetch) has a request pending
//   req1     in  m1 (data) has a request pending
//   grant_en in  a grant is being issued this cycle (updates the pointer)
//   pick     out index of the winning master
module l2arb_pick
  import l2arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic pick
);

`ifdef L2ARB_FIXED_PRIO_EN

  // m1 wins whenever it asks; m0 only gets the port when m1 is quiet.
  assign pick = req1 ? M_DATA : M_IFETCH;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, reset, req0, grant_en};

`else

  logic last_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= M_DATA;
    end else if (grant_en) begin
      last_grant <= pick;
    end
  end

  always_comb begin
    pick = M_IFETCH;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = M_DATA;
    end
  end

`endif

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares the single L2Cache service port between the instruction-fetch miss
// handler (m0) and the data miss handler (m1). One whole burst is granted at a
// time; the arbiter generates per-word addresses and a per-word acknowledge.
// Configuration macro: L2ARB_FIXED_PRIO_EN (m1 always wins simultaneous
// requests); when undefined the masters are served round-robin.
// Ports (N = 0,1):
//   clk, reset            clock (rising edge), async active-low reset
//   mN_rreq / mN_wreq     in  read / write request, held for the burst
//   mN_addr               in  burst base byte address (word aligned)
//   mN_burst_size         in  words in burst, 0 means 1
//   mN_wdata              in  write word for the current beat
//   mN_rdata              out l2_rdata passthrough
//   mN_ack                out beat transferred this cycle
//   mN_busy               out low only when mN owns the port and a beat completes
//   l2_addr               out base + 4*beat
//   l2_burst_size         out words remaining including the current one
//   l2_wdata              out owner's write word
//   l2_rreq / l2_wreq     out request to L2Cache
//   l2_rdata              in  read data from L2Cache
//   l2_busy               in  L2Cache is not completing a beat this cycle
module l2_port_arbiter
  import l2arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_rreq,
  input  logic               m0_wreq,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [BURST_W-1:0] m0_burst_size,
  input  logic [DATA_W-1:0]  m0_wdata,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m0_ack,
  output logic               m0_busy,
  input  logic               m1_rreq,
  input  logic               m1_wreq,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [BURST_W-1:0] m1_burst_size,
  input  logic [DATA_W-1:0]  m1_wdata,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic               m1_ack,
  output logic               m1_busy,
  output logic [ADDR_W-1:0]  l2_addr,
  output logic [BURST_W-1:0] l2_burst_size,
  output logic [DATA_W-1:0]  l2_wdata,
  output logic               l2_rreq,
  output logic               l2_wreq,
  input  logic [DATA_W-1:0]  l2_rdata,
  input  logic               l2_busy
);

  state_t             state;
  state_t             state_nx;
  logic               owner;
  logic               dir;
  logic [ADDR_W-1:0]  base;
  logic [BURST_W-1:0] len;
  logic [BURST_W-1:0] beat;

  logic               m0_req;
  logic               m1_req;
  logic               pick;
  logic               grant;
  logic               sel_rreq;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BURST_W-1:0] sel_size;
  logic               owner_rreq;
  logic               owner_wreq;
  logic               held;
  logic               last_beat;
  logic               beat_done;
  logic               in_burst;

  assign m0_req = m0_rreq | m0_wreq;
  assign m1_req = m1_rreq | m1_wreq;

  // Non-owner requests are only looked at here, in IDLE.
  assign grant  = (state == IDLE) && (m0_req || m1_req);

  l2arb_pick u_pick (
    .clk      (clk),
    .reset    (reset),
    .req0     (m0_req),
    .req1     (m1_req),
    .grant_en (grant),
    .pick     (pick)
  );

  assign sel_rreq   = (pick == M_DATA) ? m1_rreq       : m0_rreq;
  assign sel_addr   = (pick == M_DATA) ? m1_addr       : m0_addr;
  assign sel_size   = (pick == M_DATA) ? m1_burst_size : m0_burst_size;

  assign owner_rreq = (owner == M_DATA) ? m1_rreq : m0_rreq;
  assign owner_wreq = (owner == M_DATA) ? m1_wreq : m0_wreq;

  // Only the request line matching the latched direction keeps the burst
  // alive; the other line of the owner is ignored until the next grant.
  assign held       = (dir == DIR_READ) ? owner_rreq : owner_wreq;
  assign in_burst   = (state == BURST);
  assign last_beat  = (beat == (len - BURST_W'(1)));
  assign beat_done  = (l2_rreq || l2_wreq) && !l2_busy;

  // State register; async reset drops any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and L2 request strobes. Requests are gated combinationally by
  // the owner's live request so an abort removes them in the same cycle.
  always_comb begin
    state_nx = state;
    l2_rreq  = 1'b0;
    l2_wreq  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nx = BURST;
        end
      end
      BURST: begin
        l2_rreq = (dir == DIR_READ)  && owner_rreq;
        l2_wreq = (dir == DIR_WRITE) && owner_wreq;
        if (!held) begin
          state_nx = TURN;
        end else if (!l2_busy && last_beat) begin
          state_nx = TURN;
        end
      end
      TURN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Burst context is captured once at grant and then only the beat counter
  // moves, so mid-burst changes of the owner's address/size are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= M_IFETCH;
      dir   <= DIR_READ;
      base  <= '0;
      len   <= '0;
      beat  <= '0;
    end else if (grant) begin
      owner <= pick;
      dir   <= dir_of(sel_rreq);
      base  <= sel_addr;
      len   <= (sel_size == '0) ? BURST_W'(1) : sel_size;
      beat  <= '0;
    end else if (beat_done) begin
      beat  <= beat + BURST_W'(1);
    end
  end

  // Address/size/wdata are forced to zero outside a burst so the port is
  // quiet between bursts; address arithmetic wraps at 2^ADDR_W.
  assign l2_addr       = in_burst ? (base + {{(ADDR_W-BURST_W-2){1'b0}}, beat, 2'b00}) : '0;
  assign l2_burst_size = in_burst ? (len - beat) : '0;
  assign l2_wdata      = in_burst ? ((owner == M_DATA) ? m1_wdata : m0_wdata) : '0;

  assign m0_ack   = beat_done && (owner == M_IFETCH);
  assign m1_ack   = beat_done && (owner == M_DATA);
  assign m0_busy  = !m0_ack;
  assign m1_busy  = !m1_ack;

  assign m0_rdata = l2_rdata;
  assign m1_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (current grant record plus a one-cycle gap flag) predicts
// every output each cycle.
module tb_l2_port_arbiter;

`ifdef L2ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        m0_rreq, m0_wreq, m1_rreq, m1_wreq;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [4:0]  m0_burst_size, m1_burst_size;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_busy, m1_ack, m1_busy;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic [4:0]  l2_burst_size;
  logic        l2_rreq, l2_wreq, l2_busy;

  // stimulus vector, copied onto the DUT inputs by apply_stimulus
  logic        s_rreq [2];
  logic        s_wreq [2];
  logic [31:0] s_addr [2];
  logic [4:0]  s_size [2];
  logic [31:0] s_wdata[2];
  logic        s_busy;
  logic [31:0] s_rdata;

  // reference model: the burst currently granted, if any
  bit          md_active;
  bit          md_gap;
  bit          md_read;
  int          md_owner;
  int          md_last;
  int          md_len;
  int          md_done;
  logic [31:0] md_base;

  int total;
  int passed;
  int failed;
  int d;

  l2_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .m0_rreq       (m0_rreq),
    .m0_wreq       (m0_wreq),
    .m0_addr       (m0_addr),
    .m0_burst_size (m0_burst_size),
    .m0_wdata      (m0_wdata),
    .m0_rdata      (m0_rdata),
    .m0_ack        (m0_ack),
    .m0_busy       (m0_busy),
    .m1_rreq       (m1_rreq),
    .m1_wreq       (m1_wreq),
    .m1_addr       (m1_addr),
    .m1_burst_size (m1_burst_size),
    .m1_wdata      (m1_wdata),
    .m1_rdata      (m1_rdata),
    .m1_ack        (m1_ack),
    .m1_busy       (m1_busy),
    .l2_addr       (l2_addr),
    .l2_burst_size (l2_burst_size),
    .l2_wdata      (l2_wdata),
    .l2_rreq       (l2_rreq),
    .l2_wreq       (l2_wreq),
    .l2_rdata      (l2_rdata),
    .l2_busy       (l2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int m = 0; m < 2; m++) begin
      s_rreq[m]  = 1'b0;
      s_wreq[m]  = 1'b0;
      s_addr[m]  = 32'd0;
      s_size[m]  = 5'd0;
      s_wdata[m] = 32'd0;
    end
    s_busy  = 1'b0;
    s_rdata = 32'd0;
  endtask

  task automatic apply_stimulus();
    m0_rreq = s_rreq[0];  m0_wreq = s_wreq[0];  m0_addr = s_addr[0];
    m0_burst_size = s_size[0];  m0_wdata = s_wdata[0];
    m1_rreq = s_rreq[1];  m1_wreq = s_wreq[1];  m1_addr = s_addr[1];
    m1_burst_size = s_size[1];  m1_wdata = s_wdata[1];
    l2_busy = s_busy;  l2_rdata = s_rdata;
  endtask

  task automatic model_reset();
    md_active = 1'b0;
    md_gap    = 1'b0;
    md_read   = 1'b1;
    md_owner  = 0;
    md_last   = 1;
    md_len    = 0;
    md_done   = 0;
    md_base   = 32'd0;
  endtask

  // Expected outputs for the current inputs given the granted burst.
  task automatic check_output();
    bit held;
    bit beat;
    logic [31:0] e_addr;
    logic [31:0] e_size;
    logic [31:0] e_wdata;
    held    = md_active && (md_read ? s_rreq[md_owner] : s_wreq[md_owner]);
    beat    = held && !s_busy;
    e_addr  = md_active ? md_base + 32'(md_done) * 32'd4 : 32'd0;
    e_size  = md_active ? 32'(md_len - md_done) : 32'd0;
    e_wdata = md_active ? s_wdata[md_owner] : 32'd0;
    check("l2_rreq",       32'(l2_rreq),       32'(held && md_read));
    check("l2_wreq",       32'(l2_wreq),       32'(held && !md_read));
    check("l2_addr",       l2_addr,            e_addr);
    check("l2_burst_size", 32'(l2_burst_size), e_size);
    check("l2_wdata",      l2_wdata,           e_wdata);
    check("m0_ack",        32'(m0_ack),        32'(beat && md_owner == 0));
    check("m1_ack",        32'(m1_ack),        32'(beat && md_owner == 1));
    check("m0_busy",       32'(m0_busy),       32'(!(beat && md_owner == 0)));
    check("m1_busy",       32'(m1_busy),       32'(!(beat && md_owner == 1)));
    check("m0_rdata",      m0_rdata,           s_rdata);
    check("m1_rdata",      m1_rdata,           s_rdata);
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    bit held;
    bit r0;
    bit r1;
    int w;
    if (md_active) begin
      held = md_read ? s_rreq[md_owner] : s_wreq[md_owner];
      if (!held) begin
        md_active = 1'b0;
        md_gap    = 1'b1;
      end else if (!s_busy) begin
        md_done++;
        if (md_done == md_len) begin
          md_active = 1'b0;
          md_gap    = 1'b1;
        end
      end
    end else if (md_gap) begin
      md_gap = 1'b0;
    end else begin
      r0 = s_rreq[0] || s_wreq[0];
      r1 = s_rreq[1] || s_wreq[1];
      if (r0 || r1) begin
        if (r0 && r1) w = FIXED_PRIO ? 1 : 1 - md_last;
        else          w = r1 ? 1 : 0;
        md_last   = w;
        md_owner  = w;
        md_read   = s_rreq[w];
        md_base   = s_addr[w];
        md_len    = (s_size[w] == 5'd0) ? 1 : int'(s_size[w]);
        md_done   = 0;
        md_active = 1'b1;
      end
    end
  endtask

  // Called at a falling edge; inputs change, outputs checked 1 ns later.
  task automatic drive_and_check();
    apply_stimulus();
    #1;
    check_output();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cycle();
    drive_and_check();
    advance();
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    apply_stimulus();
    #1;
    check_output();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic pat[5];
    total  = 0;
    passed = 0;
    failed = 0;
    clear_stim();
    apply_stimulus();
    do_reset();

    // single 4-word read burst from m0 with zero-wait L2
    s_rreq[0] = 1'b1;  s_addr[0] = 32'h0000_1000;  s_size[0] = 5'd4;
    drive_and_check();
    check("t1_idle_rreq", 32'(l2_rreq), 32'd0);
    advance();
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'hD000_0000 + 32'(i);
      drive_and_check();
      check("t1_addr", l2_addr, 32'h0000_1000 + 32'(4 * i));
      check("t1_size", 32'(l2_burst_size), 32'(4 - i));
      check("t1_ack",  32'(m0_ack), 32'd1);
      advance();
    end
    s_rreq[0] = 1'b0;
    drive_and_check();
    check("t1_turn_rreq", 32'(l2_rreq), 32'd0);
    advance();
    cycle();

    // simultaneous requests, both held: alternation (or m1 forever)
    clear_stim();
    do_reset();
    s_rreq[0] = 1'b1;  s_addr[0] = 32'h0000_2000;  s_size[0] = 5'd2;
    s_wreq[1] = 1'b1;  s_addr[1] = 32'h0000_3000;  s_size[1] = 5'd1;
    s_wdata[1] = 32'h1111_2222;
    cycle();
    drive_and_check();
    check("t2_first_owner", 32'({m1_ack, m0_ack}), FIXED_PRIO ? 32'd2 : 32'd1);
    advance();
    repeat (3) cycle();
    drive_and_check();
    check("t2_second_owner", 32'({m1_ack, m0_ack}), FIXED_PRIO ? 32'd0 : 32'd2);
    advance();
    repeat (12) cycle();
    clear_stim();
    repeat (3) cycle();

    // m1 write of 2 words against a stalling L2
    clear_stim();
    do_reset();
    pat[0] = 1'b1;  pat[1] = 1'b1;  pat[2] = 1'b0;  pat[3] = 1'b1;  pat[4] = 1'b0;
    s_wreq[1] = 1'b1;  s_addr[1] = 32'h0000_4000;  s_size[1] = 5'd2;
    cycle();
    for (int i = 0; i < 5; i++) begin
      s_busy     = pat[i];
      s_wdata[1] = 32'hA000_0000 + 32'(i);
      drive_and_check();
      check("t3_ack",   32'(m1_ack), 32'(!pat[i]));
      check("t3_wdata", l2_wdata, 32'hA000_0000 + 32'(i));
      advance();
    end
    s_busy = 1'b0;
    drive_and_check();
    check("t3_turn_wreq", 32'(l2_wreq), 32'd0);
    advance();
    s_wreq[1] = 1'b0;
    repeat (2) cycle();

    // m0 aborts an 8-word read after one beat; waiting m1 follows
    clear_stim();
    do_reset();
    s_rreq[0] = 1'b1;  s_addr[0] = 32'h0000_5000;  s_size[0] = 5'd8;
    cycle();
    s_rreq[1] = 1'b1;  s_addr[1] = 32'h0000_6000;  s_size[1] = 5'd1;
    drive_and_check();
    check("t4_beat1_ack", 32'(m0_ack), 32'd1);
    check("t4_m1_wait",   32'(m1_busy), 32'd1);
    advance();
    s_rreq[0] = 1'b0;
    drive_and_check();
    check("t4_abort_rreq", 32'(l2_rreq), 32'd0);
    check("t4_abort_ack",  32'(m0_ack), 32'd0);
    advance();
    cycle();
    cycle();
    drive_and_check();
    check("t4_m1_ack",  32'(m1_ack), 32'd1);
    check("t4_m1_addr", l2_addr, 32'h0000_6000);
    advance();
    s_rreq[1] = 1'b0;
    repeat (3) cycle();

    // reset asserted during beat 3 of 6, then a fresh grant
    clear_stim();
    do_reset();
    s_rreq[0] = 1'b1;  s_addr[0] = 32'h0000_7000;  s_size[0] = 5'd6;
    repeat (3) cycle();
    drive_and_check();
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_rreq", 32'(l2_rreq), 32'd0);
    check("t5_rst_wreq", 32'(l2_wreq), 32'd0);
    check("t5_rst_busy", 32'(m0_busy), 32'd1);
    model_reset();
    check_output();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    drive_and_check();
    check("t5_base", l2_addr, 32'h0000_7000);
    check("t5_size", 32'(l2_burst_size), 32'd6);
    advance();
    s_rreq[0] = 1'b0;
    repeat (3) cycle();

    // size 0 at the top of memory, then a 2-word burst wrapping to 0
    clear_stim();
    do_reset();
    s_rreq[0] = 1'b1;  s_addr[0] = 32'hFFFF_FFFC;  s_size[0] = 5'd0;
    cycle();
    drive_and_check();
    check("t6_z_addr", l2_addr, 32'hFFFF_FFFC);
    check("t6_z_size", 32'(l2_burst_size), 32'd1);
    check("t6_z_ack",  32'(m0_ack), 32'd1);
    advance();
    s_rreq[0] = 1'b0;
    cycle();
    s_rreq[0] = 1'b1;  s_size[0] = 5'd2;
    cycle();
    drive_and_check();
    check("t6_w_addr0", l2_addr, 32'hFFFF_FFFC);
    advance();
    drive_and_check();
    check("t6_w_addr1", l2_addr, 32'h0000_0000);
    check("t6_w_size1", 32'(l2_burst_size), 32'd1);
    advance();
    s_rreq[0] = 1'b0;
    repeat (2) cycle();

    // randomized traffic from both masters against a randomly stalling L2
    clear_stim();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!(s_rreq[m] || s_wreq[m])) begin
          if ($urandom_range(3) == 0) begin
            d = int'($urandom_range(2));
            s_rreq[m] = (d != 1);
            s_wreq[m] = (d != 0);
            if ($urandom_range(3) == 0)
              s_addr[m] = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
            else
              s_addr[m] = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(3) == 0) s_size[m] = 5'($urandom_range(31));
            else                        s_size[m] = 5'($urandom_range(4));
          end
        end else if ($urandom_range(19) == 0) begin
          s_rreq[m] = 1'b0;
          s_wreq[m] = 1'b0;
        end else if ($urandom_range(9) == 0) begin
          s_addr[m] = $urandom() & 32'hFFFF_FFFC;
          s_size[m] = 5'($urandom_range(31));
        end
        s_wdata[m] = $urandom();
      end
      s_busy  = ($urandom_range(2) == 0);
      s_rdata = $urandom();
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
